// File: rtl/heap_pq_if.sv
// Request/response bundle for the heap priority queue.
// Handshake: push/pop are taken only in a cycle with busy=0; a request seen while busy=1 is dropped.
interface heap_pq_if #(
  parameter int KEY_W  = 32,
  parameter int DATA_W = 16,
  parameter int PTR_W  = 10
);
  logic              push;
  logic              pop;
  logic [KEY_W-1:0]  push_key;
  logic [DATA_W-1:0] push_data;
  logic              busy;
  logic              full;
  logic              empty;
  logic [PTR_W-1:0]  count;
  logic              top_valid;
  logic [KEY_W-1:0]  top_key;
  logic [DATA_W-1:0] top_data;
  logic              pop_valid;
  logic [KEY_W-1:0]  pop_key;
  logic [DATA_W-1:0] pop_data;

  modport master (
    output push, pop, push_key, push_data,
    input  busy, full, empty, count, top_valid, top_key, top_data,
    input  pop_valid, pop_key, pop_data
  );

  modport slave (
    input  push, pop, push_key, push_data,
    output busy, full, empty, count, top_valid, top_key, top_data,
    output pop_valid, pop_key, pop_data
  );
endinterface

// File: rtl/heap_pq.sv
// Binary-heap priority queue over a dual-port RAM (port A read/write, port B read).
// The record being sifted lives in cur_q; the RAM slot it travels through is filled only when it settles.
module heap_pq #(
  parameter int KEY_W    = 32,
  parameter int DATA_W   = 16,
  parameter int PTR_W    = 10,
  parameter int MAX_HEAP = 0
) (
  input  logic       clk,
  input  logic       rst,
  heap_pq_if.slave   pq,
  output logic [2:0] dbg_state_o
);

  localparam int DEPTH = (1 << PTR_W) - 1;
  localparam int REC_W = KEY_W + DATA_W;

  typedef enum logic [2:0] {IDLE, UP_RD, UP_CMP, DN_RD, DN_CMP} state_e;

  state_e             state_q, state_d;
  logic [PTR_W-1:0]   cnt_q, cnt_d;
  logic [PTR_W-1:0]   cur_idx_q, cur_idx_d;
  logic [REC_W-1:0]   cur_q, cur_d;
  logic               load_last_q, load_last_d;
  logic               pop_valid_q, pop_valid_d;
  logic [REC_W-1:0]   pop_rec_q, pop_rec_d;
  logic [REC_W-1:0]   top_q;

  logic [REC_W-1:0]   mem [0:DEPTH];
  logic [REC_W-1:0]   rd_a_q, rd_b_q;
  logic               we_a;
  logic [PTR_W-1:0]   addr_a, addr_b;
  logic [REC_W-1:0]   wdata_a;

  logic               full;
  logic [REC_W-1:0]   rec_in, dn_rec, child;
  logic [PTR_W:0]     l_idx, r_idx, cnt_x;
  logic [PTR_W-1:0]   par_idx, child_idx;
  logic               pick_r;

  function automatic logic [KEY_W-1:0] key_of(input logic [REC_W-1:0] r);
    return r[REC_W-1:DATA_W];
  endfunction

  // Strict compare: equal keys are never "better", so they never swap.
  function automatic logic better(input logic [KEY_W-1:0] a, input logic [KEY_W-1:0] b);
    if (MAX_HEAP != 0) return a > b;
    else               return a < b;
  endfunction

  always_ff @(posedge clk) begin
    if (we_a) mem[addr_a] <= wdata_a;
    rd_a_q <= mem[addr_a];
    rd_b_q <= mem[addr_b];
  end

  assign full      = (cnt_q == PTR_W'(DEPTH));
  assign rec_in    = {pq.push_key, pq.push_data};
  assign dn_rec    = load_last_q ? rd_a_q : cur_q;
  assign l_idx     = {cur_idx_q, 1'b0};
  assign r_idx     = l_idx | (PTR_W+1)'(1);
  assign cnt_x     = {1'b0, cnt_q};
  assign par_idx   = cur_idx_q >> 1;
  assign pick_r    = (r_idx <= cnt_x) && better(key_of(rd_b_q), key_of(rd_a_q));
  assign child     = pick_r ? rd_b_q : rd_a_q;
  assign child_idx = pick_r ? r_idx[PTR_W-1:0] : l_idx[PTR_W-1:0];

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cur_idx_d   = cur_idx_q;
    cur_d       = cur_q;
    load_last_d = 1'b0;
    pop_valid_d = 1'b0;
    pop_rec_d   = pop_rec_q;
    we_a        = 1'b0;
    addr_a      = cur_idx_q;
    wdata_a     = cur_q;
    addr_b      = '0;
    case (state_q)
      IDLE: begin
        if (pq.pop && cnt_q != '0) begin
          pop_valid_d = 1'b1;
          pop_rec_d   = top_q;
          cur_idx_d   = PTR_W'(1);
          if (pq.push) begin
            cur_d   = rec_in;
            state_d = DN_RD;
          end else begin
            cnt_d = cnt_q - PTR_W'(1);
            if (cnt_q != PTR_W'(1)) begin
              // Fetch the last record; it lands in rd_a_q during the first DN_RD.
              addr_a      = cnt_q;
              load_last_d = 1'b1;
              state_d     = DN_RD;
            end
          end
        end else if (pq.push && !full) begin
          we_a      = 1'b1;
          addr_a    = cnt_q + PTR_W'(1);
          wdata_a   = rec_in;
          cnt_d     = cnt_q + PTR_W'(1);
          cur_d     = rec_in;
          cur_idx_d = cnt_q + PTR_W'(1);
          if (cnt_q != '0) state_d = UP_RD;
        end
      end
      UP_RD: begin
        if (cur_idx_q == PTR_W'(1)) begin
          we_a    = 1'b1;
          state_d = IDLE;
        end else begin
          addr_a  = par_idx;
          state_d = UP_CMP;
        end
      end
      UP_CMP: begin
        we_a = 1'b1;
        if (better(key_of(cur_q), key_of(rd_a_q))) begin
          wdata_a   = rd_a_q;
          cur_idx_d = par_idx;
          state_d   = UP_RD;
        end else begin
          state_d = IDLE;
        end
      end
      DN_RD: begin
        cur_d = dn_rec;
        if (l_idx > cnt_x) begin
          we_a    = 1'b1;
          wdata_a = dn_rec;
          state_d = IDLE;
        end else begin
          addr_a  = l_idx[PTR_W-1:0];
          addr_b  = r_idx[PTR_W-1:0];
          state_d = DN_CMP;
        end
      end
      DN_CMP: begin
        we_a = 1'b1;
        if (better(key_of(child), key_of(cur_q))) begin
          wdata_a   = child;
          cur_idx_d = child_idx;
          state_d   = DN_RD;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      cur_idx_q   <= '0;
      cur_q       <= '0;
      load_last_q <= 1'b0;
      pop_valid_q <= 1'b0;
      pop_rec_q   <= '0;
      top_q       <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cur_idx_q   <= cur_idx_d;
      cur_q       <= cur_d;
      load_last_q <= load_last_d;
      pop_valid_q <= pop_valid_d;
      pop_rec_q   <= pop_rec_d;
      // Shadow of RAM slot 1 so the top record needs no read cycle.
      if (we_a && addr_a == PTR_W'(1)) top_q <= wdata_a;
    end
  end

  assign pq.busy      = (state_q != IDLE);
  assign pq.full      = full;
  assign pq.empty     = (cnt_q == '0);
  assign pq.count     = cnt_q;
  assign pq.top_valid = (state_q == IDLE) && (cnt_q != '0);
  assign pq.top_key   = key_of(top_q);
  assign pq.top_data  = top_q[DATA_W-1:0];
  assign pq.pop_valid = pop_valid_q;
  assign pq.pop_key   = key_of(pop_rec_q);
  assign pq.pop_data  = pop_rec_q[DATA_W-1:0];
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_heap_pq.sv
// Directed and randomized checks of heap_pq: a min-heap and a max-heap instance, both 7 entries deep.
module tb_heap_pq;

  localparam int KW = 32;
  localparam int DW = 16;
  localparam int PW = 3;
  localparam int BUSY_MAX = 2 * PW + 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          sel = 1'b0;
  logic          push_r = 1'b0, pop_r = 1'b0;
  logic [KW-1:0] key_r = '0;
  logic [DW-1:0] data_r = '0;
  logic [2:0]    dbg0, dbg1;

  heap_pq_if #(.KEY_W(KW), .DATA_W(DW), .PTR_W(PW)) if0 ();
  heap_pq_if #(.KEY_W(KW), .DATA_W(DW), .PTR_W(PW)) if1 ();

  heap_pq #(.KEY_W(KW), .DATA_W(DW), .PTR_W(PW), .MAX_HEAP(0)) u_min (
    .clk(clk), .rst(rst), .pq(if0.slave), .dbg_state_o(dbg0));
  heap_pq #(.KEY_W(KW), .DATA_W(DW), .PTR_W(PW), .MAX_HEAP(1)) u_max (
    .clk(clk), .rst(rst), .pq(if1.slave), .dbg_state_o(dbg1));

  assign if0.push = push_r & ~sel;  assign if1.push = push_r & sel;
  assign if0.pop  = pop_r & ~sel;   assign if1.pop  = pop_r & sel;
  assign if0.push_key = key_r;      assign if1.push_key = key_r;
  assign if0.push_data = data_r;    assign if1.push_data = data_r;

  logic          o_busy, o_full, o_empty, o_tv, o_pv;
  logic [PW-1:0] o_cnt;
  logic [KW-1:0] o_tkey, o_pkey;
  logic [DW-1:0] o_tdata, o_pdata;
  assign o_busy  = sel ? if1.busy      : if0.busy;
  assign o_full  = sel ? if1.full      : if0.full;
  assign o_empty = sel ? if1.empty     : if0.empty;
  assign o_tv    = sel ? if1.top_valid : if0.top_valid;
  assign o_pv    = sel ? if1.pop_valid : if0.pop_valid;
  assign o_cnt   = sel ? if1.count     : if0.count;
  assign o_tkey  = sel ? if1.top_key   : if0.top_key;
  assign o_pkey  = sel ? if1.pop_key   : if0.pop_key;
  assign o_tdata = sel ? if1.top_data  : if0.top_data;
  assign o_pdata = sel ? if1.pop_data  : if0.pop_data;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  // Values captured at N+1 of the last request, and busy cycles until settle.
  logic          g_pv, g_busy1;
  logic [KW-1:0] g_pkey;
  logic [DW-1:0] g_pdata;
  int            cyc;

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic op(input bit p, input bit q, input logic [KW-1:0] k, input logic [DW-1:0] d,
                    input bit no_wait);
    @(negedge clk);
    push_r = p; pop_r = q; key_r = k; data_r = d;
    @(posedge clk); #1;
    g_pv = o_pv; g_pkey = o_pkey; g_pdata = o_pdata; g_busy1 = o_busy;
    push_r = 1'b0; pop_r = 1'b0;
    cyc = 0;
    if (!no_wait) begin
      while (o_busy && cyc < 40) begin
        @(posedge clk); #1;
        cyc++;
      end
    end
  endtask

  typedef struct {
    bit            push;
    bit            pop;
    logic [KW-1:0] key;
    bit            tv;
    logic [KW-1:0] top;
    int            cnt;
    bit            pv;
    logic [KW-1:0] pkey;
  } vec_t;
  vec_t vt[$];

  function automatic void add(bit p, bit q, int k, bit tv, int top, int cnt, bit pv, int pkey);
    vec_t v;
    v.push = p; v.pop = q; v.key = KW'(k); v.tv = tv; v.top = KW'(top);
    v.cnt = cnt; v.pv = pv; v.pkey = KW'(pkey);
    vt.push_back(v);
  endfunction

  // Scoreboard for the random phase: {key, data} records currently stored.
  logic [KW+DW-1:0] exp_q[$];

  function automatic logic [KW-1:0] best_key(input bit is_max);
    logic [KW-1:0] b;
    b = exp_q[0][KW+DW-1:DW];
    foreach (exp_q[i]) begin
      if (is_max ? (exp_q[i][KW+DW-1:DW] > b) : (exp_q[i][KW+DW-1:DW] < b)) b = exp_q[i][KW+DW-1:DW];
    end
    return b;
  endfunction

  function automatic int find_rec(input logic [KW-1:0] k, input logic [DW-1:0] d);
    foreach (exp_q[i]) if (exp_q[i] == {k, d}) return i;
    return -1;
  endfunction

  initial begin
    logic [DW-1:0] d1, d2;
    bit p, q, e_pop, e_push;
    logic [KW-1:0] k, bk;
    int idx;

    do_reset();
    @(posedge clk); #1;
    chk("rst_count", o_cnt, 0);
    chk("rst_empty", o_empty, 1);
    chk("rst_full", o_full, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_tv", o_tv, 0);
    chk("rst_tkey", o_tkey, 0);
    chk("rst_pv", o_pv, 0);
    chk("rst_pkey", o_pkey, 0);

    // push, pop, key, top_valid, top, count, pop_valid, pop_key
    add(1, 0, 30, 1, 30, 1, 0, 0);
    add(1, 0, 10, 1, 10, 2, 0, 0);
    add(1, 0, 20, 1, 10, 3, 0, 0);
    add(0, 1, 0,  1, 20, 2, 1, 10);
    add(0, 1, 0,  1, 30, 1, 1, 20);
    add(0, 1, 0,  0, 0,  0, 1, 30);
    add(0, 1, 0,  0, 0,  0, 0, 0);
    add(1, 1, 5,  1, 5,  1, 0, 0);
    add(0, 1, 0,  0, 0,  0, 1, 5);
    for (int i = 7; i >= 1; i--) add(1, 0, i, 1, i, 8 - i, 0, 0);
    add(1, 0, 0, 1, 1, 7, 0, 0);
    add(1, 1, 0, 1, 0, 7, 1, 1);
    add(0, 1, 0, 1, 2, 6, 1, 0);
    for (int i = 2; i <= 6; i++) add(0, 1, 0, 1, i + 1, 7 - i, 1, i);
    add(0, 1, 0, 0, 0, 0, 1, 7);

    sel = 1'b0;
    foreach (vt[i]) begin
      op(vt[i].push, vt[i].pop, vt[i].key, DW'(vt[i].key + 100), 0);
      chk("tbl_pv", g_pv, vt[i].pv);
      if (vt[i].pv) begin
        chk("tbl_pkey", g_pkey, vt[i].pkey);
        chk("tbl_pdata", g_pdata, DW'(vt[i].pkey + 100));
      end
      chk("tbl_busy_bound", cyc <= BUSY_MAX, 1);
      chk("tbl_count", o_cnt, vt[i].cnt);
      chk("tbl_empty", o_empty, vt[i].cnt == 0);
      chk("tbl_full", o_full, vt[i].cnt == 7);
      chk("tbl_tv", o_tv, vt[i].tv);
      if (vt[i].tv) begin
        chk("tbl_tkey", o_tkey, vt[i].top);
        chk("tbl_tdata", o_tdata, DW'(vt[i].top + 100));
      end
      if (vt[i].pv) begin
        @(posedge clk); #1;
        chk("tbl_pv_strobe", o_pv, 0);
      end
    end

    // Max-heap with duplicate keys.
    sel = 1'b1;
    op(1, 0, 5, 500, 0);
    op(1, 0, 9, 901, 0);
    op(1, 0, 9, 902, 0);
    op(1, 0, 2, 200, 0);
    chk("max_top", o_tkey, 9);
    chk("max_count", o_cnt, 4);
    op(0, 1, 0, 0, 0);
    chk("max_pop1", g_pkey, 9);
    d1 = g_pdata;
    op(0, 1, 0, 0, 0);
    chk("max_pop2", g_pkey, 9);
    d2 = g_pdata;
    chk("max_pair", (d1 == 901 && d2 == 902) || (d1 == 902 && d2 == 901), 1);
    chk("max_top_after", o_tkey, 5);
    chk("max_count_after", o_cnt, 2);

    // Reset in the middle of a sift-down.
    sel = 1'b0;
    do_reset();
    for (int i = 1; i <= 5; i++) op(1, 0, KW'(i), DW'(i), 0);
    op(0, 1, 0, 0, 1);
    chk("mid_busy", g_busy1, 1);
    chk("mid_pkey", g_pkey, 1);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_empty", o_empty, 1);
    chk("mid_rst_count", o_cnt, 0);
    chk("mid_rst_busy", o_busy, 0);
    chk("mid_rst_tv", o_tv, 0);
    @(negedge clk); rst = 1'b0;
    op(1, 0, 4, 44, 1);
    chk("mid_push_tkey", o_tkey, 4);
    chk("mid_push_tv", o_tv, 1);
    chk("mid_push_busy", g_busy1, 0);
    chk("mid_push_count", o_cnt, 1);

    // Random mix against the scoreboard, both orderings.
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      do_reset();
      exp_q.delete();
      for (int n = 0; n < 1500; n++) begin
        p = 1'($urandom_range(0, 1));
        q = 1'($urandom_range(0, 1));
        k = KW'($urandom_range(0, 15));
        e_pop  = q && exp_q.size() > 0;
        e_push = p && (exp_q.size() < 7 || e_pop);
        bk = (exp_q.size() > 0) ? best_key(sel) : '0;
        op(p, q, k, DW'(n), 0);
        chk("st_pv", g_pv, e_pop);
        if (e_pop) begin
          chk("st_pkey", g_pkey, bk);
          idx = find_rec(g_pkey, g_pdata);
          chk("st_prec", idx >= 0, 1);
          if (idx >= 0) exp_q.delete(idx);
        end
        if (e_push) exp_q.push_back({k, DW'(n)});
        chk("st_busy_bound", cyc <= BUSY_MAX, 1);
        chk("st_count", o_cnt, exp_q.size());
        chk("st_tv", o_tv, exp_q.size() > 0);
        if (exp_q.size() > 0) begin
          chk("st_tkey", o_tkey, best_key(sel));
          chk("st_trec", find_rec(o_tkey, o_tdata) >= 0, 1);
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
